// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file.
// Arbitration is round-robin. The write port is registered, and writes to
// register 0 are dropped and counted.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              stall,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [7:0]        drop_count
);

  logic              prio_q, prio_d;
  logic              wr_enable_q, wr_enable_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_src_q, wr_src_d;
  logic [7:0]        drop_q, drop_d;

  logic              a_grant, b_grant, accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Grant decision: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!reset && !stall) begin
      if (a_valid && b_valid) begin
        a_grant = ~prio_q;
        b_grant = prio_q;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  assign a_ready  = a_grant;
  assign b_ready  = b_grant;
  assign accept   = a_grant | b_grant;
  assign win_addr = b_grant ? b_addr : a_addr;
  assign win_data = b_grant ? b_data : a_data;

  // Next-state: load the winner, hand priority to the loser, and count dropped register-0 writes.
  always_comb begin
    prio_d      = prio_q;
    wr_enable_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_src_d    = wr_src_q;
    drop_d      = drop_q;
    if (accept) begin
      prio_d      = ~b_grant;
      wr_addr_d   = win_addr;
      wr_data_d   = win_data;
      wr_src_d    = b_grant;
      wr_enable_d = (win_addr != '0);
      if ((win_addr == '0) && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= 1'b0;
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_src_q    <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      prio_q      <= prio_d;
      wr_enable_q <= wr_enable_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_src_q    <= wr_src_d;
      drop_q      <= drop_d;
    end
  end

  // A pending write is cancelled as soon as reset is raised, even before the reset edge.
  assign wr_enable  = wr_enable_q & ~reset;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_src     = wr_src_q;
  assign drop_count = drop_q;

endmodule
